// File: rtl/whack_input_capture_if.sv
// Switch/mole bundle between the game logic and the input capture block.
// master drives switches, moles and game controls; slave returns debounced levels and scoring.
interface whack_input_capture_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] switches_i;
  logic [WIDTH-1:0] moles_i;
  logic             enable_i;
  logic             clear_i;
  logic [WIDTH-1:0] switches_db_o;
  logic             whack_o;
  logic [3:0]       whack_idx_o;
  logic             miss_o;
  logic [15:0]      hit_count_o;
  logic             armed_o;

  modport master (
    output switches_i, moles_i, enable_i, clear_i,
    input  switches_db_o, whack_o, whack_idx_o, miss_o, hit_count_o, armed_o
  );

  modport slave (
    input  switches_i, moles_i, enable_i, clear_i,
    output switches_db_o, whack_o, whack_idx_o, miss_o, hit_count_o, armed_o
  );
endinterface

// File: rtl/whack_input_capture.sv
// Slide-switch debouncer and whack-a-mole hit/miss scorer.
// Each lane synchronizes and debounces one switch; the top classifies lane events against lit moles.
module whack_lane #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic tick,
  input  logic load,
  input  logic sw,
  output logic db,
  output logic evt
);
  logic [1:0] sync;
  logic [2:0] cnt;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
      evt  <= 1'b0;
    end else begin
      sync <= {sync[0], sw};
      evt  <= 1'b0;
      if (tick) begin
        if (load) begin
          // initial capture: adopt the current level silently
          db  <= sync[1];
          cnt <= '0;
        end else if (sync[1] != db) begin
          if (cnt == 3'(STABLE_SAMPLES - 1)) begin
            db  <= ~db;
            cnt <= '0;
            evt <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end
endmodule

module whack_input_capture #(
  parameter int WIDTH          = 16,
  parameter int SAMPLE_CYCLES  = 100000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  whack_input_capture_if.slave  bus
);
  localparam int PW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic {CAPTURE, RUN} state_t;

  state_t           state;
  logic [PW-1:0]    pre;
  logic             tick;
  logic [WIDTH-1:0] db, evt, hits;
  logic [3:0]       hit_idx;
  logic             whack, miss;
  logic [3:0]       whack_idx;
  logic [15:0]      hit_cnt;

  assign tick = (pre == PW'(SAMPLE_CYCLES - 1));

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    whack_lane #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_lane (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .tick    (tick),
      .load    (state == CAPTURE),
      .sw      (bus.switches_i[g]),
      .db      (db[g]),
      .evt     (evt[g])
    );
  end

  assign hits = evt & bus.moles_i;

  always_comb begin
    hit_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (hits[i]) hit_idx = 4'(i);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= CAPTURE;
      whack     <= 1'b0;
      miss      <= 1'b0;
      whack_idx <= '0;
      hit_cnt   <= '0;
    end else begin
      whack <= 1'b0;
      miss  <= 1'b0;
      case (state)
        CAPTURE: if (tick) state <= RUN;
        RUN: if (bus.enable_i) begin
          if (|hits) begin
            whack     <= 1'b1;
            whack_idx <= hit_idx;
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
          end else if (|evt) begin
            miss <= 1'b1;
          end
        end
        default: state <= CAPTURE;
      endcase
      // clear wins over a same-cycle hit, but the whack pulse above still fires
      if (bus.clear_i) hit_cnt <= '0;
    end
  end

  assign bus.switches_db_o = db;
  assign bus.whack_o       = whack;
  assign bus.whack_idx_o   = whack_idx;
  assign bus.miss_o        = miss;
  assign bus.hit_count_o   = hit_cnt;
  assign bus.armed_o       = (state == RUN);
endmodule

// File: tb/tb_whack_input_capture.sv
// Bench for whack_input_capture: directed scenarios plus random toggling,
// every cycle compared against a rule-level reference model.
module tb_whack_input_capture;
  localparam int W  = 16;
  localparam int SC = 4;
  localparam int SS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  whack_input_capture_if #(.WIDTH(W)) bus ();

  whack_input_capture #(.WIDTH(W), .SAMPLE_CYCLES(SC), .STABLE_SAMPLES(SS)) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_db, m_evt;
  int           m_cnt [W];
  int           m_n;
  bit           m_armed, m_whack, m_miss;
  logic [3:0]   m_idx;
  logic [15:0]  m_count;

  int n_whack, n_miss;
  logic [W-1:0] sw_cur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_evt = '0; m_n = 0;
    m_armed = 0; m_whack = 0; m_miss = 0; m_idx = '0; m_count = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] sw, input logic [W-1:0] mo,
                            input logic en, input logic clr);
    logic [W-1:0] hits, nevt;
    bit tk, found;
    tk = ((m_n + 1) % SC) == 0;
    m_n++;
    m_whack = 0;
    m_miss  = 0;
    if (m_armed && en) begin
      hits = m_evt & mo;
      if (hits != '0) begin
        m_whack = 1;
        found = 0;
        for (int i = 0; i < W; i++)
          if (hits[i] && !found) begin m_idx = 4'(i); found = 1; end
        if (m_count != 16'hFFFF) m_count++;
      end else if (m_evt != '0) begin
        m_miss = 1;
      end
    end
    if (clr) m_count = '0;
    nevt = '0;
    if (tk) begin
      if (!m_armed) begin
        m_db = m_s2;
        m_armed = 1;
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
        for (int i = 0; i < W; i++) begin
          if (m_s2[i] != m_db[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == SS) begin
              m_db[i] = ~m_db[i];
              m_cnt[i] = 0;
              nevt[i] = 1'b1;
            end
          end else begin
            m_cnt[i] = 0;
          end
        end
      end
    end
    m_evt = nevt;
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  task automatic step();
    logic [W-1:0] sw, mo;
    logic en, clr;
    sw = bus.switches_i; mo = bus.moles_i; en = bus.enable_i; clr = bus.clear_i;
    @(posedge clk);
    if (rst_n) model_edge(sw, mo, en, clr);
    #1;
    chk("db", 32'(bus.switches_db_o), 32'(m_db));
    chk("armed", 32'(bus.armed_o), 32'(m_armed));
    chk("whack", 32'(bus.whack_o), 32'(m_whack));
    chk("miss", 32'(bus.miss_o), 32'(m_miss));
    chk("idx", 32'(bus.whack_idx_o), 32'(m_idx));
    chk("count", 32'(bus.hit_count_o), 32'(m_count));
    if (bus.whack_o) n_whack++;
    if (bus.miss_o) n_miss++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [15:0] c0;
    model_reset();
    sw_cur = 16'h0005;
    bus.switches_i = sw_cur;
    bus.moles_i = '0;
    bus.enable_i = 1'b0;
    bus.clear_i = 1'b0;
    n_whack = 0; n_miss = 0;

    // reset and initial capture
    run(3);
    rst_n = 1'b1;
    run(8);
    chk("cap_db", 32'(bus.switches_db_o), 32'h0005);
    chk("cap_armed", 32'(bus.armed_o), 32'd1);
    chk("cap_pulses", 32'(n_whack + n_miss), 32'd0);

    // single hit on lane 3
    bus.enable_i = 1'b1;
    bus.moles_i = 16'h0008;
    n_whack = 0; n_miss = 0;
    sw_cur[3] = ~sw_cur[3];
    bus.switches_i = sw_cur;
    run(24);
    chk("hit3_n", 32'(n_whack), 32'd1);
    chk("hit3_idx", 32'(bus.whack_idx_o), 32'd3);
    chk("hit3_cnt", 32'(bus.hit_count_o), 32'd1);
    chk("hit3_db", 32'(bus.switches_db_o), 32'h000D);

    // 2-tick glitch on lane 7 is rejected
    n_whack = 0; n_miss = 0;
    bus.switches_i = sw_cur ^ 16'h0080;
    run(8);
    bus.switches_i = sw_cur;
    run(20);
    chk("glitch_db", 32'(bus.switches_db_o), 32'h000D);
    chk("glitch_pulses", 32'(n_whack + n_miss), 32'd0);

    // lanes 2 and 9 together: hit then miss
    n_whack = 0; n_miss = 0;
    c0 = bus.hit_count_o;
    bus.moles_i = 16'h0204;
    sw_cur ^= 16'h0204;
    bus.switches_i = sw_cur;
    run(24);
    chk("dual_whack", 32'(n_whack), 32'd1);
    chk("dual_idx", 32'(bus.whack_idx_o), 32'd2);
    chk("dual_cnt", 32'(bus.hit_count_o), 32'(c0 + 16'd1));
    n_whack = 0; n_miss = 0;
    bus.moles_i = '0;
    sw_cur ^= 16'h0204;
    bus.switches_i = sw_cur;
    run(24);
    chk("dual_miss", 32'(n_miss), 32'd1);
    chk("dual_miss_w", 32'(n_whack), 32'd0);

    // saturation
    force dut.hit_cnt = 16'hFFFF;
    #1;
    release dut.hit_cnt;
    m_count = 16'hFFFF;
    n_whack = 0;
    bus.moles_i = 16'h0008;
    sw_cur[3] = ~sw_cur[3];
    bus.switches_i = sw_cur;
    run(24);
    chk("sat_cnt", 32'(bus.hit_count_o), 32'hFFFF);
    chk("sat_whack", 32'(n_whack), 32'd1);

    // clear in the same cycle as a hit
    n_whack = 0;
    sw_cur[3] = ~sw_cur[3];
    bus.switches_i = sw_cur;
    for (int i = 0; i < 24; i++) begin
      bus.clear_i = (m_evt != '0);
      step();
    end
    bus.clear_i = 1'b0;
    chk("clr_cnt", 32'(bus.hit_count_o), 32'd0);
    chk("clr_whack", 32'(n_whack), 32'd1);

    // reset pulse in mid-debounce on lane 5
    n_whack = 0; n_miss = 0;
    bus.moles_i = 16'h0020;
    sw_cur[5] = ~sw_cur[5];
    bus.switches_i = sw_cur;
    run(6);
    rst_n = 1'b0;
    model_reset();
    step();
    chk("rst_db", 32'(bus.switches_db_o), 32'd0);
    chk("rst_armed", 32'(bus.armed_o), 32'd0);
    chk("rst_cnt", 32'(bus.hit_count_o), 32'd0);
    rst_n = 1'b1;
    run(30);
    chk("rst_rearm", 32'(bus.armed_o), 32'd1);
    chk("rst_db2", 32'(bus.switches_db_o), 32'(sw_cur));
    chk("rst_pulses", 32'(n_whack + n_miss), 32'd0);

    // randomized play
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) sw_cur[$urandom_range(0, W - 1)] ^= 1'b1;
      bus.switches_i = sw_cur;
      bus.moles_i = 16'($urandom);
      bus.enable_i = ($urandom_range(0, 7) != 0);
      bus.clear_i = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/whack_input_capture.md
WHACK_INPUT_CAPTURE -- requirements
Module: whack_input_capture

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 16, number of switch/mole lanes, 2..16.
- SAMPLE_CYCLES, 100000, clock cycles between debounce sample ticks (1 ms at 100 MHz).
- STABLE_SAMPLES, 4, consecutive equal samples required to accept a new switch level, 2..7.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock_i, in, 1, single system clock; all logic on the rising edge.
- reset_i, in, 1, asynchronous active-low reset.
- switches_i, in, WIDTH, raw asynchronous slide switches.
- moles_i, in, WIDTH, currently lit moles, synchronous to clock_i.
- enable_i, in, 1, 1 = game in progress; events are scored.
- clear_i, in, 1, synchronous clear of hit_count_o.
- switches_db_o, out, WIDTH, debounced switch levels.
- whack_o, out, 1, one-cycle pulse: a scored hit.
- whack_idx_o, out, 4, lane index of the hit; held until the next hit.
- miss_o, out, 1, one-cycle pulse: toggle on a lane with no mole.
- hit_count_o, out, 16, saturating hit counter.
- armed_o, out, 1, 1 once the initial switch levels have been captured.

Function
REQ-003 Each switches_i bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-004 A free-running prescaler SHALL assert an internal tick for one cycle every SAMPLE_CYCLES cycles; the first tick is SAMPLE_CYCLES cycles after reset release.
REQ-005 On each tick, per lane: if the synchronized bit differs from switches_db_o, a 3-bit stable counter SHALL increment; otherwise it SHALL clear to 0.
REQ-006 When a lane's stable counter reaches STABLE_SAMPLES, switches_db_o for that lane SHALL invert in that same cycle, and its counter SHALL clear.
REQ-007 A lane event SHALL be a change of switches_db_o in either direction, registered for use in the next cycle.
REQ-008 The state machine SHALL have two states:
- CAPTURE: entered from reset. On the first tick, switches_db_o loads the synchronized input directly, with no events; then go to RUN.
- RUN: armed_o = 1.
REQ-009 In RUN with enable_i=1, events SHALL be classified on the cycle after acceptance:
- Hit: event lane has moles_i = 1, sampled in that cycle.
- Miss: event lane has moles_i = 0.
REQ-010 If at least one hit exists in a cycle:
- whack_o SHALL pulse for one cycle.
- whack_idx_o SHALL take the lowest-indexed hit lane.
- hit_count_o SHALL increment by exactly 1.
- miss_o SHALL stay 0.
REQ-011 If events exist but none are hits, miss_o SHALL pulse for one cycle; whack_o and hit_count_o SHALL be unaffected.
REQ-012 With enable_i=0 or in CAPTURE, debouncing SHALL continue, and whack_o and miss_o SHALL stay 0.
REQ-013 hit_count_o SHALL saturate at 16'hFFFF.
REQ-014 clear_i SHALL set hit_count_o to 0 and takes priority over a simultaneous hit; that hit's whack_o still pulses.
REQ-015 Latency SHALL be: a stable input change is reflected on switches_db_o at the STABLE_SAMPLES-th tick after it passes the synchronizer, and on whack_o/miss_o one cycle later.
REQ-016 Glitches shorter than STABLE_SAMPLES consecutive ticks SHALL NOT change switches_db_o.

Reset
REQ-017 While reset_i=0, outputs SHALL be:
- switches_db_o = 0, whack_o = 0, whack_idx_o = 0, miss_o = 0, hit_count_o = 0, armed_o = 0.
- Prescaler, stable counters and synchronizers cleared; state = CAPTURE.
REQ-018 Reset asserted mid-debounce or mid-pulse SHALL abort immediately, with no pulse emitted after release until CAPTURE completes.

Verification (SAMPLE_CYCLES=4, STABLE_SAMPLES=3)
REQ-019 The bench SHALL cover these directed scenarios:
- Reset release with switches_i=16'h0005 -> armed_o=1 and switches_db_o=16'h0005 after the first tick; whack_o=0 and miss_o=0 throughout.
- enable_i=1, moles_i[3]=1, switches_i[3] toggled and held -> switches_db_o[3] flips on the 3rd tick; whack_o pulses once the next cycle; whack_idx_o=3; hit_count_o=1.
- A 2-tick pulse on switches_i[7] -> switches_db_o unchanged; no whack_o or miss_o.
- Lanes 2 and 9 toggled together, moles_i=16'h0204 -> one whack_o pulse, whack_idx_o=2, hit_count_o +1; same with moles_i=0 -> one miss_o pulse.
- hit_count_o preloaded to 16'hFFFF plus a hit -> stays 16'hFFFF; clear_i with a hit in the same cycle -> count 0 and whack_o pulses.
- reset_i low for 1 cycle in the middle of a debounce -> all outputs 0, armed_o returns after the next tick, no stale pulse.
